video_stream_source_8bit: RTL and testbench
===========================================

# video_stream_source_8bit

Frame-timing generator and pixel reader: the transmitting end of the 8-bit vsync/href/clken video stream consumed by the window, filter and morphology stages. It reads a stored grayscale frame from a synchronous single-port image RAM in raster order and emits it with programmable vertical and horizontal blanking. It drives image-processing pipelines from BRAM in simulation and on hardware.

## Interface
- H_ACTIVE, 640: active pixels per line
- H_BLANK, 160: blank clocks per line, after the active region
- V_SYNC, 2: lines with vsync high at the start of each frame
- V_BACK, 2: blank lines after the sync lines
- V_ACTIVE, 480: active lines
- V_FRONT, 2: blank lines at the end of each frame
- ADDR_W, 19: image RAM address width; must satisfy 2^ADDR_W ≥ H_ACTIVE·V_ACTIVE

Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle request to send a frame
- continuous  in  1  sampled at end of frame; 1 = start the next frame immediately
- rd_en  out  1  RAM read enable
- rd_addr  out  ADDR_W  RAM read address
- rd_data  in  8  RAM read data, valid the cycle after rd_en
- per_frame_vsync  out  1  frame sync, active high
- per_frame_href  out  1  active-line window
- per_frame_clken  out  1  pixel valid
- per_img_y  out  8  pixel value
- busy  out  1  high in RUN
- frame_done  out  1  one-cycle pulse after the last clock of a frame

## Operation
- FSM IDLE/RUN. IDLE: counters are held at 0. frame_start → RUN, with h_cnt = 0, v_cnt = 0 and rd_addr = 0 starting on the next cycle.
- h_cnt counts 0..LINE−1, where LINE = H_ACTIVE + H_BLANK. It wraps to 0 and increments v_cnt.
- v_cnt counts 0..FRAME_LINES−1, where FRAME_LINES = V_SYNC + V_BACK + V_ACTIVE + V_FRONT.
- Stage-0 signals:
  - pre_vsync = (v_cnt < V_SYNC)
  - pre_href = (line is active) && (h_cnt < H_ACTIVE)
  - pre_clken = pre_href
- rd_en = pre_clken. rd_addr increments after each rd_en. It is not reset per line. It is reset to 0 at each frame start.
- End of frame (last h_cnt of the last line): frame_done pulses.
  - If continuous = 1, the FSM stays in RUN and restarts the counters at 0.
  - Otherwise the FSM goes to IDLE.
- frame_start while in RUN is ignored, including on the end-of-frame cycle.
- Counter widths are $clog2 of their ranges. No arithmetic overflow is permitted by construction.

## Timing
- Control outputs are stage-0 signals delayed by exactly 2 registers.
- per_img_y is registered and loads rd_data when the 1-stage-delayed clken is high.
- Net result: per_frame_clken and the matching per_img_y appear 2 cycles after the rd_en for that pixel.
- per_img_y holds its value when clken is low inside href. It is 0 when href is low.
- The first frame's per_frame_vsync rises 3 cycles after the frame_start cycle: 1 cycle into RUN, plus 2 cycles of delay.
- frame_done is asserted during the last stage-0 cycle, so it leads the last output stage by 2 cycles.
- busy is high from the cycle after frame_start until the cycle after the frame_done cycle.
- Reset, asynchronous and at any time, including mid-frame, sets:
  - the FSM to IDLE and all counters, delay registers and rd_addr to 0
  - all outputs to 0
  - No partial line or frame is resumed after reset.

## Configuration
- VIDEO_SRC_CLKEN_THROTTLE_EN
- Defined:
  - LINE = 2·H_ACTIVE + H_BLANK.
  - pre_href is high for h_cnt < 2·H_ACTIVE.
  - pre_clken = pre_href && !h_cnt[0], i.e. one pixel every 2 clocks. This exercises the receivers' clken hold paths.
  - rd_en follows pre_clken.
- Undefined: clken equals href, one pixel per clock, as specified above.

## Test plan
Use H_ACTIVE=4, H_BLANK=3, V_SYNC=1, V_BACK=1, V_ACTIVE=3, V_FRONT=1, with RAM[i] = i+1.
- Single frame, continuous=0:
  - vsync is high for 7 cycles, then 7 blank cycles.
  - Then 3 lines, each with 4 clken+href cycles carrying 1..4, 5..8 and 9..12, followed by 3 idle cycles.
  - frame_done pulses once at 42 clocks.
  - busy then drops, and rd_addr is back at 0 at the next start.
- Continuous=1 for 2 frames: the second vsync rising edge is exactly 42 cycles after the first, and pixels 1..12 repeat.
- frame_start pulsed mid-frame: it is ignored. The frame length stays 42, and no extra frame_done pulse occurs.
- Reset asserted at pixel 6: all outputs are 0 immediately, per the asynchronous reset. After release and a new frame_start, the first pixel is 1.
- Throttle macro defined:
  - LINE=11; href is high for 8 cycles per active line.
  - clken is high on alternate cycles, carrying 1,2,3,4.
  - per_img_y holds its value on the gap cycles.
- Outside href, per_img_y = 0. Latency from rd_en to clken is exactly 2 cycles for every pixel.

Source files
------------

// File: rtl/video_stream_source_8bit.sv
// video_stream_source_8bit: reads a grayscale frame from image RAM in raster order and emits it as a vsync/href/clken stream
// Ports: clk/rst (async, active high); frame_start starts a frame, continuous chains frames;
// rd_en/rd_addr/rd_data drive a 1-cycle-latency RAM; per_frame_vsync/href/clken and per_img_y form the stream;
// busy is high while a frame is generated, frame_done marks its last clock.
// Optional: define VIDEO_SRC_CLKEN_THROTTLE_EN to send one pixel every 2 clocks inside a doubled href window.
module video_stream_source_8bit #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 2,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 2,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              continuous,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              per_frame_vsync,
  output logic              per_frame_href,
  output logic              per_frame_clken,
  output logic [7:0]        per_img_y,
  output logic              busy,
  output logic              frame_done
);
`ifdef VIDEO_SRC_CLKEN_THROTTLE_EN
  localparam int HREF_END = 2 * H_ACTIVE;
`else
  localparam int HREF_END = H_ACTIVE;
`endif
  localparam int LINE        = HREF_END + H_BLANK;
  localparam int FRAME_LINES = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HW          = $clog2(LINE);
  localparam int VW          = $clog2(FRAME_LINES);
  typedef enum logic {IDLE, RUN} state_t;
  state_t            state, state_nx;
  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic              run, last, active_line;
  logic              pre_vsync, pre_href, pre_clken;
  logic [1:0]        vs_d, hr_d, ck_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_comb
    state_nx = (state == IDLE) ? (frame_start ? RUN : IDLE)
                               : ((last && !continuous) ? IDLE : RUN);
  always_comb begin
    run         = (state == RUN);
    last        = run && 32'(h_cnt) == LINE - 1 && 32'(v_cnt) == FRAME_LINES - 1;
    active_line = 32'(v_cnt) >= V_SYNC + V_BACK && 32'(v_cnt) < V_SYNC + V_BACK + V_ACTIVE;
    pre_vsync   = run && 32'(v_cnt) < V_SYNC;
    pre_href    = run && active_line && 32'(h_cnt) < HREF_END;
`ifdef VIDEO_SRC_CLKEN_THROTTLE_EN
    pre_clken   = pre_href && !h_cnt[0];
`else
    pre_clken   = pre_href;
`endif
    rd_en           = pre_clken;
    busy            = run;
    frame_done      = last;
    per_frame_vsync = vs_d[1];
    per_frame_href  = hr_d[1];
    per_frame_clken = ck_d[1];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      rd_addr   <= '0;
      vs_d      <= '0;
      hr_d      <= '0;
      ck_d      <= '0;
      per_img_y <= '0;
    end else begin
      // Counters and address sit at 0 outside RUN and after the last cycle, so each frame starts clean.
      h_cnt     <= (!run || last || 32'(h_cnt) == LINE - 1) ? '0 : h_cnt + 1'b1;
      v_cnt     <= (!run || last) ? '0 : (32'(h_cnt) == LINE - 1) ? v_cnt + 1'b1 : v_cnt;
      rd_addr   <= (!run || last) ? '0 : rd_addr + ADDR_W'(rd_en);
      vs_d      <= {vs_d[0], pre_vsync};
      hr_d      <= {hr_d[0], pre_href};
      ck_d      <= {ck_d[0], pre_clken};
      // RAM data for a stage-0 read is valid one cycle later, aligned with the first delay stage.
      per_img_y <= !hr_d[0] ? 8'd0 : ck_d[0] ? rd_data : per_img_y;
    end
endmodule

// File: tb/tb_video_stream_source_8bit.sv
// tb_video_stream_source_8bit: directed checks of frame timing, pixel order, chaining, ignored starts and async reset
module tb_video_stream_source_8bit;
  localparam int FL = 42;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       continuous = 1'b0;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] rd_data = 8'd0;
  logic       vsync, href, clken, busy, frame_done;
  logic [7:0] y;
  int         checks = 0;
  int         errors = 0;
  int         cur_n = 0;
  video_stream_source_8bit #(
    .H_ACTIVE(4), .H_BLANK(3), .V_SYNC(1), .V_BACK(1), .V_ACTIVE(3), .V_FRONT(1), .ADDR_W(4)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .continuous(continuous),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
    .per_img_y(y), .busy(busy), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (rd_en) rd_data <= 8'(rd_addr) + 8'd1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d: observed %0h expected %0h", tag, cur_n, obs, exp);
    end
  endtask
  function automatic void model(input int t, input int f, output int v, output int h, output int py, output int a);
    int kk, ln, c;
    v = 0; h = 0; py = 0; a = 0;
    if (t >= 0 && t < FL * f) begin
      kk = t % FL; ln = kk / 7; c = kk % 7;
      v  = (ln == 0) ? 1 : 0;
      h  = (ln >= 2 && ln <= 4 && c < 4) ? 1 : 0;
      py = h ? (ln - 2) * 4 + c + 1 : 0;
      a  = (ln < 2) ? 0 : (ln <= 4) ? (ln - 2) * 4 + ((c < 4) ? c : 4) : 12;
    end
  endfunction
  task automatic run_frame(input int f, input int pa, input int pb, input int stop);
    int v, h, py, a, sv, sh, sy, sa;
    cur_n = 0;
    chk("idle_busy", busy, 0);
    chk("idle_addr", rd_addr, 0);
    continuous = (f > 1);
    frame_start = 1'b1;
    for (int n = 1; n <= ((stop > 0) ? stop : FL * f + 5); n++) begin
      @(negedge clk);
      cur_n = n;
      frame_start = 1'b0;
      if (n == FL + 1) continuous = 1'b0;
      model(n - 3, f, v, h, py, a);
      model(n - 1, f, sv, sh, sy, sa);
      chk("vsync", vsync, v);
      chk("href", href, h);
      chk("clken", clken, h);
      chk("pixel", y, py);
      chk("rd_en", rd_en, sh);
      chk("rd_addr", rd_addr, sa);
      chk("frame_done", frame_done, (n % FL == 0 && n <= FL * f) ? 1 : 0);
      chk("busy", busy, (n <= FL * f) ? 1 : 0);
      if (n == pa || n == pb) frame_start = 1'b1;
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_vsync", vsync, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pixel", y, 0);
    chk("rst_rd_en", rd_en, 0);
    rst = 1'b0;
    @(negedge clk);
    run_frame(1, 0, 0, 0);
    run_frame(2, 0, 0, 0);
    run_frame(1, 20, FL, 0);
    @(negedge clk);
    run_frame(1, 0, 0, 25);
    chk("pix6_before_rst", y, 6);
    #1 rst = 1'b1;
    #1;
    chk("arst_vsync", vsync, 0);
    chk("arst_href", href, 0);
    chk("arst_clken", clken, 0);
    chk("arst_pixel", y, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rd_en", rd_en, 0);
    chk("arst_rd_addr", rd_addr, 0);
    chk("arst_done", frame_done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame(1, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
